// File: rtl/sim_sweep_scheduler.sv
// Raster-sweep scheduler: once per game tick it walks the X_MAX x Y_MAX grid, driving the
// write cell/strobe and a view cell that leads the writer by LOOKAHEAD cells.
module sim_sweep_scheduler #(
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 7,
  parameter int X_MAX     = 159,
  parameter int Y_MAX     = 119,
  parameter int LOOKAHEAD = 2,
  parameter int SLOW_BITS = 26
) (
  input  logic                 clk,
  input  logic                 RESET_SIM,
  input  logic                 run,
  input  logic                 pause_req,
  input  logic                 step_req,
  input  logic [SLOW_BITS-1:0] factor,
  output logic [X_BITS-1:0]    writeLoc_x,
  output logic [Y_BITS-1:0]    writeLoc_y,
  output logic [X_BITS-1:0]    viewLoc_x,
  output logic [Y_BITS-1:0]    viewLoc_y,
  output logic                 write_flag,
  output logic                 hold_locs,
  output logic                 frame_done,
  output logic [15:0]          frame_count,
  output logic                 overrun,
  output logic [2:0]           state
);

  localparam int CELLS    = (X_MAX + 1) * (Y_MAX + 1);
  localparam int CNT_BITS = $clog2(CELLS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    PRIME  = 3'd2,
    SWEEP  = 3'd3,
    PAUSED = 3'd4
  } state_t;

  localparam logic [X_BITS-1:0]   X_LAST     = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0]   Y_LAST     = Y_BITS'(Y_MAX);
  localparam logic [CNT_BITS-1:0] PRIME_LAST = CNT_BITS'((LOOKAHEAD == 0) ? 0 : LOOKAHEAD - 1);
  localparam state_t              FRAME_START = (LOOKAHEAD == 0) ? SWEEP : PRIME;

  state_t                state_q, state_d;
  logic [X_BITS-1:0]     wx_q, wx_d, vx_q, vx_d;
  logic [Y_BITS-1:0]     wy_q, wy_d, vy_q, vy_d;
  logic                  wf_q, wf_d, hold_q, hold_d, done_q, done_d, ovr_q, ovr_d;
  logic [15:0]           fc_q, fc_d;
  logic [SLOW_BITS-1:0]  tick_cnt_q, tick_cnt_d, factor_eff;
  logic [CNT_BITS-1:0]   prime_cnt_q, prime_cnt_d;
  logic                  step_frame_q, step_frame_d;
  logic                  tick;

  function automatic logic [X_BITS-1:0] next_x(input logic [X_BITS-1:0] x);
    return (x == X_LAST) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [Y_BITS-1:0] next_y(input logic [X_BITS-1:0] x,
                                               input logic [Y_BITS-1:0] y);
    if (x != X_LAST) return y;
    return (y == Y_LAST) ? '0 : y + 1'b1;
  endfunction

  always_comb begin
    factor_eff   = (factor == '0) ? SLOW_BITS'(1) : factor;
    // >= keeps the counter sane if factor shrinks below the current count
    tick         = run && (tick_cnt_q >= factor_eff - 1'b1);
    tick_cnt_d   = (!run || tick) ? '0 : tick_cnt_q + 1'b1;

    state_d      = state_q;
    wx_d         = wx_q;
    wy_d         = wy_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    done_d       = 1'b0;
    fc_d         = fc_q;
    ovr_d        = ovr_q;
    prime_cnt_d  = prime_cnt_q;
    step_frame_d = step_frame_q;

    if ((state_q == PRIME || state_q == SWEEP) && tick)
      ovr_d = 1'b1;

    if (!run) begin
      state_d = IDLE;
      wx_d    = '0;
      wy_d    = '0;
      vx_d    = '0;
      vy_d    = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          if (tick) begin
            state_d      = FRAME_START;
            step_frame_d = 1'b0;
            prime_cnt_d  = '0;
          end
        end
        PRIME: begin
          vx_d        = next_x(vx_q);
          vy_d        = next_y(vx_q, vy_q);
          prime_cnt_d = prime_cnt_q + 1'b1;
          if (prime_cnt_q == PRIME_LAST)
            state_d = SWEEP;
        end
        SWEEP: begin
          if (wx_q == X_LAST && wy_q == Y_LAST) begin
            done_d  = 1'b1;
            fc_d    = fc_q + 16'd1;
            wx_d    = '0;
            wy_d    = '0;
            vx_d    = '0;
            vy_d    = '0;
            state_d = (pause_req || step_frame_q) ? PAUSED : WAIT;
          end else begin
            wx_d = next_x(wx_q);
            wy_d = next_y(wx_q, wy_q);
            vx_d = next_x(vx_q);
            vy_d = next_y(vx_q, vy_q);
          end
        end
        PAUSED: begin
          if (!pause_req) begin
            state_d = WAIT;
          end else if (step_req) begin
            state_d      = FRAME_START;
            step_frame_d = 1'b1;
            prime_cnt_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    wf_d   = (state_d == SWEEP);
    hold_d = !(state_d == PRIME || state_d == SWEEP);
  end

  always_ff @(posedge clk) begin
    if (RESET_SIM) begin
      state_q      <= IDLE;
      wx_q         <= '0;
      wy_q         <= '0;
      vx_q         <= '0;
      vy_q         <= '0;
      wf_q         <= 1'b0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
      fc_q         <= '0;
      ovr_q        <= 1'b0;
      tick_cnt_q   <= '0;
      prime_cnt_q  <= '0;
      step_frame_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      wf_q         <= wf_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      fc_q         <= fc_d;
      ovr_q        <= ovr_d;
      tick_cnt_q   <= tick_cnt_d;
      prime_cnt_q  <= prime_cnt_d;
      step_frame_q <= step_frame_d;
    end
  end

  assign writeLoc_x  = wx_q;
  assign writeLoc_y  = wy_q;
  assign viewLoc_x   = vx_q;
  assign viewLoc_y   = vy_q;
  assign write_flag  = wf_q;
  assign hold_locs   = hold_q;
  assign frame_done  = done_q;
  assign frame_count = fc_q;
  assign overrun     = ovr_q;
  assign state       = state_q;

endmodule

// File: tb/tb_sim_sweep_scheduler.sv
// Bench for sim_sweep_scheduler: a 4x3 grid with LOOKAHEAD=2 and LOOKAHEAD=0 instances,
// both compared every cycle against a frame-phase reference model.
module tb_sim_sweep_scheduler;

  localparam int XM = 3;
  localparam int YM = 2;
  localparam int N  = (XM + 1) * (YM + 1);

  localparam int M_IDLE   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_RUN    = 2;
  localparam int M_PAUSED = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, pause_req, step_req;
  logic [25:0] factor;

  logic [7:0]  wx[2], vx[2];
  logic [6:0]  wy[2], vy[2];
  logic        wf[2], hold[2], done[2], ovr[2];
  logic [15:0] fc[2];
  logic [2:0]  st[2];

  sim_sweep_scheduler #(.X_MAX(XM), .Y_MAX(YM), .LOOKAHEAD(2)) u_dut (
    .clk(clk), .RESET_SIM(rst), .run(run), .pause_req(pause_req), .step_req(step_req),
    .factor(factor), .writeLoc_x(wx[0]), .writeLoc_y(wy[0]), .viewLoc_x(vx[0]),
    .viewLoc_y(vy[0]), .write_flag(wf[0]), .hold_locs(hold[0]), .frame_done(done[0]),
    .frame_count(fc[0]), .overrun(ovr[0]), .state(st[0])
  );

  sim_sweep_scheduler #(.X_MAX(XM), .Y_MAX(YM), .LOOKAHEAD(0)) u_dut_la0 (
    .clk(clk), .RESET_SIM(rst), .run(run), .pause_req(pause_req), .step_req(step_req),
    .factor(factor), .writeLoc_x(wx[1]), .writeLoc_y(wy[1]), .viewLoc_x(vx[1]),
    .viewLoc_y(vy[1]), .write_flag(wf[1]), .hold_locs(hold[1]), .frame_done(done[1]),
    .frame_count(fc[1]), .overrun(ovr[1]), .state(st[1])
  );

  // Reference model: a frame is a phase p counting 0..L+N-1 from the tick that starts it.
  int m_mode[2];
  int m_p[2];
  int m_step[2];
  int m_fc[2];
  int m_ovr[2];
  int m_done[2];
  int m_tcnt;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int la(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE;
      m_p[k]    = 0;
      m_step[k] = 0;
      m_fc[k]   = 0;
      m_ovr[k]  = 0;
      m_done[k] = 0;
    end
    m_tcnt = 0;
  endtask

  task automatic model_step();
    int fmax;
    bit t;
    if (rst) begin
      model_reset();
      return;
    end
    fmax   = (factor == 0) ? 1 : int'(factor);
    t      = run && (m_tcnt >= fmax - 1);
    m_tcnt = (!run || t) ? 0 : m_tcnt + 1;
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0;
      if (!run) begin
        m_mode[k] = M_IDLE;
      end else begin
        case (m_mode[k])
          M_IDLE: m_mode[k] = M_WAIT;
          M_WAIT: if (t) begin m_mode[k] = M_RUN; m_p[k] = 0; m_step[k] = 0; end
          M_RUN: begin
            if (t) m_ovr[k] = 1;
            if (m_p[k] == la(k) + N - 1) begin
              m_done[k] = 1;
              m_fc[k]   = (m_fc[k] + 1) % 65536;
              m_mode[k] = (pause_req || m_step[k] != 0) ? M_PAUSED : M_WAIT;
            end else begin
              m_p[k]++;
            end
          end
          default: begin
            if (!pause_req) m_mode[k] = M_WAIT;
            else if (step_req) begin m_mode[k] = M_RUN; m_p[k] = 0; m_step[k] = 1; end
          end
        endcase
      end
    end
  endtask

  task automatic check_all();
    int e_state, e_wf, e_wx, e_wy, e_vx, e_vy, vi;
    for (int k = 0; k < 2; k++) begin
      e_state = 0; e_wf = 0; e_wx = 0; e_wy = 0; e_vx = 0; e_vy = 0;
      case (m_mode[k])
        M_IDLE:   e_state = 0;
        M_WAIT:   e_state = 1;
        M_PAUSED: e_state = 4;
        default: begin
          e_state = (m_p[k] < la(k)) ? 2 : 3;
          vi   = m_p[k] % N;
          e_vx = vi % (XM + 1);
          e_vy = vi / (XM + 1);
          if (m_p[k] >= la(k)) begin
            e_wf = 1;
            e_wx = (m_p[k] - la(k)) % (XM + 1);
            e_wy = (m_p[k] - la(k)) / (XM + 1);
          end
        end
      endcase
      check($sformatf("state[%0d]", k),       st[k],   e_state);
      check($sformatf("write_flag[%0d]", k),  wf[k],   e_wf);
      check($sformatf("writeLoc_x[%0d]", k),  wx[k],   e_wx);
      check($sformatf("writeLoc_y[%0d]", k),  wy[k],   e_wy);
      check($sformatf("viewLoc_x[%0d]", k),   vx[k],   e_vx);
      check($sformatf("viewLoc_y[%0d]", k),   vy[k],   e_vy);
      check($sformatf("hold_locs[%0d]", k),   hold[k], (m_mode[k] == M_RUN) ? 0 : 1);
      check($sformatf("frame_done[%0d]", k),  done[k], m_done[k]);
      check($sformatf("frame_count[%0d]", k), fc[k],   m_fc[k]);
      check($sformatf("overrun[%0d]", k),     ovr[k],  m_ovr[k]);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_write(input int x, input int y, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick_clk();
      hit = wf[0] && wx[0] == x && wy[0] == y;
    end
    check($sformatf("wait_write_%0d_%0d", x, y), hit, 1);
  endtask

  task automatic wait_state(input int s, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick_clk();
      hit = (st[0] == s);
    end
    check($sformatf("wait_state_%0d", s), hit, 1);
  endtask

  initial begin
    model_reset();
    rst = 1'b1; run = 1'b0; pause_req = 1'b0; step_req = 1'b0; factor = 26'd40;
    repeat (3) tick_clk();
    rst = 1'b0;

    // basic frames
    run = 1'b1;
    repeat (100) tick_clk();

    // pause mid-frame, then step, then release together with a step
    wait_write(1, 1, 100);
    pause_req = 1'b1;
    repeat (120) tick_clk();
    step_req = 1'b1; tick_clk(); step_req = 1'b0;
    repeat (30) tick_clk();
    step_req = 1'b1; pause_req = 1'b0; tick_clk(); step_req = 1'b0;
    repeat (60) tick_clk();

    // overrun
    factor = 26'd5;
    repeat (60) tick_clk();

    // abort mid-sweep
    factor = 26'd40;
    wait_write(2, 1, 200);
    run = 1'b0; tick_clk(); run = 1'b1;
    repeat (50) tick_clk();

    // reset mid-sweep
    wait_state(3, 200);
    rst = 1'b1; tick_clk(); rst = 1'b0;
    repeat (20) tick_clk();

    // factor 0: tick every cycle
    factor = '0;
    repeat (40) tick_clk();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) factor = 26'($urandom_range(0, 40));
      run      = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 29) == 0) pause_req = ~pause_req;
      step_req = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 799) == 0);
      tick_clk();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
